// File: rtl/fetch_stage_pkg.sv
// ---------------------------------------------------------------------------
// fetch_stage_pkg
// Shared pipeline definitions for the MIPS front end: the NOP bubble word,
// the reset PC, the opcode/funct values that identify control-flow
// instructions, the next-PC select encoding and small helper functions.
// ---------------------------------------------------------------------------
package fetch_stage_pkg;

  // sll $0,$0,0 -- the bubble inserted into IF/ID on a flush
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  // Opcode / funct fields of the control-flow instructions
  localparam logic [5:0] OPCODE_SPECIAL = 6'b000000;
  localparam logic [5:0] OPCODE_J       = 6'b000010;
  localparam logic [5:0] OPCODE_JAL     = 6'b000011;
  localparam logic [5:0] FUNCT_JR       = 6'b001000;

  // Next-PC source select
  typedef enum logic [1:0] {
    PC_SEL_SEQ    = 2'b00,
    PC_SEL_JUMP   = 2'b01,
    PC_SEL_JR     = 2'b10,
    PC_SEL_BRANCH = 2'b11
  } pcSel_e;

  // Free-running debug counters stick at all-ones instead of wrapping
  function automatic logic [31:0] satIncr(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

  // Decode helpers for the stages that sit next to fetch
  function automatic logic isJumpInstr(input logic [31:0] instr);
    return (instr[31:26] == OPCODE_J) || (instr[31:26] == OPCODE_JAL);
  endfunction

  function automatic logic isJrInstr(input logic [31:0] instr);
    return (instr[31:26] == OPCODE_SPECIAL) && (instr[5:0] == FUNCT_JR);
  endfunction

endpackage

// File: rtl/fetch_stage_if_id_register.sv
// ---------------------------------------------------------------------------
// if_id_register
// IF/ID pipeline register: a 64-bit payload ({instruction, PC+4}) plus a
// valid bit. Flush has priority over write and loads the NOP bubble; with
// neither asserted the contents hold. Reset loads the bubble.
//
// Ports:
//   clk_i    rising-edge clock
//   rst_i    asynchronous active-high reset
//   write_i  load data_i and mark valid
//   flush_i  load the bubble (wins over write_i)
//   data_i   {instruction, PC+4} from fetch
//   data_o   registered {instruction, PC+4}
//   valid_o  0 when the register holds a bubble
// ---------------------------------------------------------------------------
module if_id_register
  import fetch_stage_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        write_i,
  input  logic        flush_i,
  input  logic [63:0] data_i,
  output logic [63:0] data_o,
  output logic        valid_o
);

  localparam logic [63:0] BUBBLE = {NOP_WORD, 32'h0000_0000};

  logic [63:0] data_q, data_d;
  logic        valid_q, valid_d;

  // Flush beats write, so a squashed slot never picks up fetched data
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (flush_i) begin
      data_d  = BUBBLE;
      valid_d = 1'b0;
    end else if (write_i) begin
      data_d  = data_i;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_q  <= BUBBLE;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
// Instruction-fetch stage: program counter, next-PC selection (branch > jr >
// jump > sequential), instruction-memory address, the IF/ID register and
// saturating stall/flush counters for performance debug.
//
// Ports:
//   Clk, Rst              clock, asynchronous active-high reset
//   PCWrite               0 = hold PC (a redirect still loads)
//   IF_ID_Write           0 = hold IF/ID
//   IF_ID_Flush           1 = load the bubble into IF/ID
//   BranchTaken/Target    EX-stage branch redirect
//   JrTaken/Target        jr redirect
//   JumpTaken/Target      j/jal redirect
//   InstrAddr, InstrData  instruction memory address / combinational data
//   PC                    current fetch PC
//   IF_ID_*               registered instruction, PC+4 and valid
//   StallCount            cycles with PCWrite=0 and no redirect
//   FlushCount            cycles with IF_ID_Flush=1
// ---------------------------------------------------------------------------
module fetch_stage
  import fetch_stage_pkg::*;
(
  input  logic        Clk,
  input  logic        Rst,
  input  logic        PCWrite,
  input  logic        IF_ID_Write,
  input  logic        IF_ID_Flush,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic        JrTaken,
  input  logic [31:0] JrTarget,
  input  logic        JumpTaken,
  input  logic [31:0] JumpTarget,
  output logic [31:0] InstrAddr,
  input  logic [31:0] InstrData,
  output logic [31:0] PC,
  output logic [31:0] IF_ID_Instruction,
  output logic [31:0] IF_ID_PCPlus4,
  output logic        IF_ID_Valid,
  output logic [31:0] StallCount,
  output logic [31:0] FlushCount
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] pcPlus4;
  pcSel_e      pcSel;
  logic [31:0] redirectTarget;
  logic        redirect;
  logic        stallEvent;
  logic [31:0] stallCount_q, stallCount_d;
  logic [31:0] flushCount_q, flushCount_d;
  logic [63:0] ifIdData;

  assign pcPlus4 = pc_q + 32'd4;

  // Oldest stage wins: the branch in EX overrides younger jr/jump decisions
  always_comb begin
    pcSel = PC_SEL_SEQ;
    if (BranchTaken) begin
      pcSel = PC_SEL_BRANCH;
    end else if (JrTaken) begin
      pcSel = PC_SEL_JR;
    end else if (JumpTaken) begin
      pcSel = PC_SEL_JUMP;
    end
  end

  always_comb begin
    redirectTarget = pcPlus4;
    case (pcSel)
      PC_SEL_BRANCH: redirectTarget = BranchTarget;
      PC_SEL_JR:     redirectTarget = JrTarget;
      PC_SEL_JUMP:   redirectTarget = JumpTarget;
      default:       redirectTarget = pcPlus4;
    endcase
  end

  assign redirect   = (pcSel != PC_SEL_SEQ);
  assign stallEvent = !PCWrite && !redirect;

  // A redirect loads even during a stall so it is never lost; the low two
  // bits are cleared to keep the PC word aligned
  always_comb begin
    pc_d = pc_q;
    if (redirect) begin
      pc_d = redirectTarget & ~32'd3;
    end else if (PCWrite) begin
      pc_d = pcPlus4;
    end
  end

  always_comb begin
    stallCount_d = stallCount_q;
    flushCount_d = flushCount_q;
    if (stallEvent) begin
      stallCount_d = satIncr(stallCount_q);
    end
    if (IF_ID_Flush) begin
      flushCount_d = satIncr(flushCount_q);
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      pc_q         <= RESET_PC;
      stallCount_q <= 32'd0;
      flushCount_q <= 32'd0;
    end else begin
      pc_q         <= pc_d;
      stallCount_q <= stallCount_d;
      flushCount_q <= flushCount_d;
    end
  end

  if_id_register u_if_id (
    .clk_i   (Clk),
    .rst_i   (Rst),
    .write_i (IF_ID_Write),
    .flush_i (IF_ID_Flush),
    .data_i  ({InstrData, pcPlus4}),
    .data_o  (ifIdData),
    .valid_o (IF_ID_Valid)
  );

  assign IF_ID_Instruction = ifIdData[63:32];
  assign IF_ID_PCPlus4     = ifIdData[31:0];
  assign InstrAddr         = pc_q;
  assign PC                = pc_q;
  assign StallCount        = stallCount_q;
  assign FlushCount        = flushCount_q;

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
// Table-driven bench for fetch_stage with a scoreboard queue of expected
// results, plus hand-written sequences for counter saturation and an
// asynchronous reset asserted in the middle of a redirect.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pcWrite = 1'b1, ifIdWrite = 1'b1, ifIdFlush = 1'b0;
  logic        branchTaken = 1'b0, jrTaken = 1'b0, jumpTaken = 1'b0;
  logic [31:0] branchTarget = '0, jrTarget = '0, jumpTarget = '0;
  logic [31:0] instrAddr, instrData, pc, ifIdInstruction, ifIdPcPlus4;
  logic        ifIdValid;
  logic [31:0] stallCount, flushCount;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic        pcw, ifw, flush;
    logic        br;  logic [31:0] brT;
    logic        jr;  logic [31:0] jrT;
    logic        j;   logic [31:0] jT;
    logic [31:0] expPc;
    logic        expValid;
    logic [31:0] expAddr;
    logic [31:0] expStall, expFlush;
  } row_t;

  typedef struct {
    logic [31:0] pc, instr, pc4;
    logic        valid;
    logic [31:0] stall, flush;
  } exp_t;

  row_t vec[$];
  exp_t expQ[$];

  always #5 clk = ~clk;

  // Address-derived instruction memory so every word is distinguishable
  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  assign instrData = memWord(instrAddr);

  fetch_stage dut (
    .Clk               (clk),
    .Rst               (rst),
    .PCWrite           (pcWrite),
    .IF_ID_Write       (ifIdWrite),
    .IF_ID_Flush       (ifIdFlush),
    .BranchTaken       (branchTaken),
    .BranchTarget      (branchTarget),
    .JrTaken           (jrTaken),
    .JrTarget          (jrTarget),
    .JumpTaken         (jumpTaken),
    .JumpTarget        (jumpTarget),
    .InstrAddr         (instrAddr),
    .InstrData         (instrData),
    .PC                (pc),
    .IF_ID_Instruction (ifIdInstruction),
    .IF_ID_PCPlus4     (ifIdPcPlus4),
    .IF_ID_Valid       (ifIdValid),
    .StallCount        (stallCount),
    .FlushCount        (flushCount)
  );

  task automatic addRow(input logic pcw, ifw, flush,
                        input logic br, input logic [31:0] brT,
                        input logic jr, input logic [31:0] jrT,
                        input logic j,  input logic [31:0] jT,
                        input logic [31:0] expPc, input logic expValid,
                        input logic [31:0] expAddr,
                        input logic [31:0] expStall, expFlush);
    row_t r;
    r.pcw = pcw; r.ifw = ifw; r.flush = flush;
    r.br = br; r.brT = brT; r.jr = jr; r.jrT = jrT; r.j = j; r.jT = jT;
    r.expPc = expPc; r.expValid = expValid; r.expAddr = expAddr;
    r.expStall = expStall; r.expFlush = expFlush;
    vec.push_back(r);
  endtask

  task automatic pushExpected(input row_t r);
    exp_t e;
    e.pc    = r.expPc;
    e.valid = r.expValid;
    e.instr = r.expValid ? memWord(r.expAddr) : 32'h0;
    e.pc4   = r.expValid ? r.expAddr + 32'd4 : 32'h0;
    e.stall = r.expStall;
    e.flush = r.expFlush;
    expQ.push_back(e);
  endtask

  // Drives one row's controls and records what the DUT must show after the edge
  task automatic applyStimulus(input row_t r);
    pcWrite = r.pcw; ifIdWrite = r.ifw; ifIdFlush = r.flush;
    branchTaken = r.br; branchTarget = r.brT;
    jrTaken = r.jr; jrTarget = r.jrT;
    jumpTaken = r.j; jumpTarget = r.jT;
    pushExpected(r);
  endtask

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    exp_t e;
    if (expQ.size() == 0) begin
      total++;
      bad++;
      $display("[TB] FAIL %s: scoreboard empty got 1 expected 0", tag);
      return;
    end
    e = expQ.pop_front();
    compare({tag, ".PC"}, pc, e.pc);
    compare({tag, ".InstrAddr"}, instrAddr, e.pc);
    compare({tag, ".Instr"}, ifIdInstruction, e.instr);
    compare({tag, ".PCPlus4"}, ifIdPcPlus4, e.pc4);
    compare({tag, ".Valid"}, {31'd0, ifIdValid}, {31'd0, e.valid});
    compare({tag, ".Stall"}, stallCount, e.stall);
    compare({tag, ".Flush"}, flushCount, e.flush);
  endtask

  row_t tmp;

  initial begin
    // Sequential fetch, stall, redirects with priority, flush, alignment, wrap
    //     pcw ifw fl  br brT          jr jrT          j  jT            expPc        v  expAddr      stall flush
    addRow(1, 1, 0,  0, 0,           0, 0,           0, 0,            32'h4,        1, 32'h0,        0, 0);
    addRow(1, 1, 0,  0, 0,           0, 0,           0, 0,            32'h8,        1, 32'h4,        0, 0);
    addRow(1, 1, 0,  0, 0,           0, 0,           0, 0,            32'hC,        1, 32'h8,        0, 0);
    addRow(1, 1, 0,  0, 0,           0, 0,           0, 0,            32'h10,       1, 32'hC,        0, 0);
    addRow(0, 0, 0,  0, 0,           0, 0,           0, 0,            32'h10,       1, 32'hC,        1, 0);
    addRow(0, 0, 0,  0, 0,           0, 0,           0, 0,            32'h10,       1, 32'hC,        2, 0);
    addRow(0, 0, 0,  0, 0,           0, 0,           0, 0,            32'h10,       1, 32'hC,        3, 0);
    addRow(1, 1, 0,  0, 0,           0, 0,           0, 0,            32'h14,       1, 32'h10,       3, 0);
    addRow(0, 0, 0,  1, 32'h40,      0, 0,           1, 32'h80,       32'h40,       1, 32'h10,       3, 0);
    addRow(1, 1, 0,  0, 0,           0, 0,           0, 0,            32'h44,       1, 32'h40,       3, 0);
    addRow(1, 0, 1,  0, 0,           0, 0,           0, 0,            32'h48,       0, 32'h0,        3, 1);
    addRow(0, 1, 1,  0, 0,           0, 0,           0, 0,            32'h48,       0, 32'h0,        4, 2);
    addRow(1, 1, 0,  0, 0,           1, 32'h103,     0, 0,            32'h100,      1, 32'h48,       4, 2);
    addRow(1, 1, 0,  0, 0,           0, 0,           0, 0,            32'h104,      1, 32'h100,      4, 2);
    addRow(1, 1, 0,  0, 0,           1, 32'h200,     1, 32'h300,      32'h200,      1, 32'h104,      4, 2);
    addRow(1, 1, 0,  1, 32'h3,       1, 32'h8,       0, 0,            32'h0,        1, 32'h200,      4, 2);
    addRow(1, 1, 0,  0, 0,           0, 0,           1, 32'hFFFF_FFFE, 32'hFFFF_FFFC, 1, 32'h0,      4, 2);
    addRow(1, 1, 0,  0, 0,           0, 0,           0, 0,            32'h0,        1, 32'hFFFF_FFFC, 4, 2);
    addRow(0, 0, 0,  0, 0,           0, 0,           1, 32'h30,       32'h30,       1, 32'hFFFF_FFFC, 4, 2);
    addRow(1, 1, 0,  0, 0,           0, 0,           0, 0,            32'h34,       1, 32'h30,       4, 2);

    // Reset state, held across edges
    repeat (2) @(posedge clk);
    @(negedge clk);
    tmp = '{default: '0};
    pushExpected(tmp);
    checkOutput("reset");

    rst = 1'b0;
    for (int i = 0; i < vec.size(); i++) begin
      applyStimulus(vec[i]);
      @(posedge clk);
      #1;
      checkOutput($sformatf("row%0d", i));
      @(negedge clk);
    end

    // Stall counter saturation: preload just below the ceiling
    tmp = '{pcw: 0, ifw: 0, flush: 0, br: 0, brT: 0, jr: 0, jrT: 0, j: 0, jT: 0,
            expPc: 32'h34, expValid: 1, expAddr: 32'h30,
            expStall: 32'hFFFF_FFFF, expFlush: 2};
    applyStimulus(tmp);
    force dut.stallCount_q = 32'hFFFF_FFFE;
    #1;
    release dut.stallCount_q;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) pushExpected(tmp);
      @(posedge clk);
      #1;
      checkOutput($sformatf("sat%0d", i));
      @(negedge clk);
    end

    // Asynchronous reset in the middle of a stalled branch redirect
    tmp = '{pcw: 0, ifw: 1, flush: 0, br: 1, brT: 32'h500, jr: 0, jrT: 0, j: 0, jT: 0,
            expPc: 0, expValid: 0, expAddr: 0, expStall: 0, expFlush: 0};
    applyStimulus(tmp);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("asyncRst");
    pushExpected(tmp);
    @(posedge clk);
    #1;
    checkOutput("rstHeld");
    @(negedge clk);
    tmp = '{pcw: 1, ifw: 1, flush: 0, br: 0, brT: 0, jr: 0, jrT: 0, j: 0, jT: 0,
            expPc: 32'h4, expValid: 1, expAddr: 32'h0, expStall: 0, expFlush: 0};
    applyStimulus(tmp);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("postRst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
